// File: rtl/apb_req_arbiter_pkg.sv
// Shared types and defaults for the APB requester arbiter.
// The state enum is common to the arbiter and any wrapper that inspects it.
package apb_req_arbiter_pkg;

  localparam int DEF_NREQ    = 4;
  localparam int DEF_AW      = 4;
  localparam int DEF_DW      = 8;
  localparam int DEF_TIMEOUT = 64;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_SETUP,
    WAIT_ACCESS,
    DONE
  } arb_state_e;

endpackage

// File: rtl/apb_req_arbiter_if.sv
// Requester-side and APB-snoop signals of the arbiter, grouped as one bundle.
// The master modport is the arbiter; the slave modport is its environment.
interface apb_req_arbiter_if
  import apb_req_arbiter_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int AW   = DEF_AW,
  parameter int DW   = DEF_DW
);

  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    req_wr;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    ack;
  logic [DW-1:0]      rdata;
  logic               m_newd;
  logic               m_wr;
  logic [AW-1:0]      m_addr;
  logic [DW-1:0]      m_wdata;
  logic               psel;
  logic               penable;
  logic               pready;
  logic [DW-1:0]      prdata;
  logic               busy;
  logic               timeout;

  modport master (
    input  req, req_wr, req_addr, req_wdata, psel, penable, pready, prdata,
    output ack, rdata, m_newd, m_wr, m_addr, m_wdata, busy, timeout
  );

  modport slave (
    output req, req_wr, req_addr, req_wdata, psel, penable, pready, prdata,
    input  ack, rdata, m_newd, m_wr, m_addr, m_wdata, busy, timeout
  );

endinterface

// File: rtl/apb_req_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request strictly after i_last,
// scanning upward with wrap; i_last itself is considered last.
module apb_req_arbiter_rr_pick #(
  parameter  int NREQ = 4,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_last,
  output logic [NREQ-1:0] o_gnt,
  output logic [IW-1:0]   o_idx,
  output logic            o_any
);

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!o_any && i_req[(int'(i_last) + k) % NREQ]) begin
        o_any = 1'b1;
        o_idx = IW'((int'(i_last) + k) % NREQ);
        o_gnt[(int'(i_last) + k) % NREQ] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB master command port between NREQ
// requesters; tracks each transfer by snooping psel/penable/pready.
//
// state       | meaning
// IDLE        | no grant; picker chooses next requester, command latched
// ISSUE       | m_newd pulse to the APB master
// WAIT_SETUP  | waiting for the APB setup phase
// WAIT_ACCESS | waiting for psel && penable && pready
// DONE        | one-cycle ack to the granted requester
module apb_req_arbiter
  import apb_req_arbiter_pkg::*;
#(
  parameter int NREQ    = DEF_NREQ,
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input logic               pclk,
  input logic               preset,
  apb_req_arbiter_if.master bus
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  arb_state_e      r_state, w_state_nxt;
  logic [IW-1:0]   r_gnt_idx, r_last;
  logic [NREQ-1:0] r_gnt_oh;
  logic            r_m_wr;
  logic [AW-1:0]   r_m_addr;
  logic [DW-1:0]   r_m_wdata;
  logic [DW-1:0]   r_rdata;
  logic [CW-1:0]   r_wdog;
  logic            r_timeout;

  logic [NREQ-1:0] w_pick_gnt;
  logic [IW-1:0]   w_pick_idx;
  logic            w_pick_any;
  logic            w_capture;
  logic            w_xfer_done;
  logic [NREQ-1:0] w_ack;
  logic            w_newd;
  logic            w_busy;

  apb_req_arbiter_rr_pick #(.NREQ(NREQ)) u_pick (
    .i_req  (bus.req),
    .i_last (r_last),
    .o_gnt  (w_pick_gnt),
    .o_idx  (w_pick_idx),
    .o_any  (w_pick_any)
  );

  assign w_xfer_done = bus.psel & bus.penable & bus.pready;

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_ack       = '0;
    w_newd      = 1'b0;
    w_busy      = (r_state != IDLE);
    unique case (r_state)
      IDLE:        if (w_pick_any) w_state_nxt = ISSUE;
      ISSUE: begin
        w_newd      = 1'b1;
        w_state_nxt = WAIT_SETUP;
      end
      WAIT_SETUP: begin
        // A master that skips straight to access is checked for completion here.
        if (bus.psel && bus.penable) begin
          if (bus.pready) begin
            w_capture   = 1'b1;
            w_state_nxt = DONE;
          end else begin
            w_state_nxt = WAIT_ACCESS;
          end
        end else if (bus.psel) begin
          w_state_nxt = WAIT_ACCESS;
        end
      end
      WAIT_ACCESS: begin
        if (w_xfer_done) begin
          w_capture   = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_ack       = r_gnt_oh;
        w_state_nxt = IDLE;
      end
      default:     w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state   <= IDLE;
      r_gnt_idx <= '0;
      r_gnt_oh  <= '0;
      r_last    <= IW'(NREQ - 1);
      r_m_wr    <= 1'b0;
      r_m_addr  <= '0;
      r_m_wdata <= '0;
      r_rdata   <= '0;
      r_wdog    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && w_pick_any) begin
        r_gnt_idx <= w_pick_idx;
        r_gnt_oh  <= w_pick_gnt;
        r_m_wr    <= bus.req_wr[w_pick_idx];
        r_m_addr  <= bus.req_addr[int'(w_pick_idx)*AW +: AW];
        r_m_wdata <= bus.req_wdata[int'(w_pick_idx)*DW +: DW];
      end
      if (w_capture && !r_m_wr) r_rdata <= bus.prdata;
      if (r_state == DONE) r_last <= r_gnt_idx;
      // Watchdog value equals the number of cycles elapsed since the m_newd cycle.
      if (r_state == IDLE || r_state == DONE) begin
        r_wdog <= '0;
      end else if (r_wdog != CW'(TIMEOUT)) begin
        r_wdog <= r_wdog + CW'(1);
        if (r_wdog == CW'(TIMEOUT - 1)) r_timeout <= 1'b1;
      end
    end
  end

  assign bus.ack     = w_ack;
  assign bus.rdata   = r_rdata;
  assign bus.m_newd  = w_newd;
  assign bus.m_wr    = r_m_wr;
  assign bus.m_addr  = r_m_addr;
  assign bus.m_wdata = r_m_wdata;
  assign bus.busy    = w_busy;
  assign bus.timeout = r_timeout;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter: the bench plays the APB master/slave
// reacting to m_newd, and checks acks, data, ordering, latency and watchdog.
module tb_apb_req_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 4;
  localparam int DW   = 8;
  localparam int TO   = 16;

  logic pclk = 1'b0;
  logic preset;

  apb_req_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  apb_req_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TO)) u_dut (
    .pclk   (pclk),
    .preset (preset),
    .bus    (bus)
  );

  always #5 pclk = ~pclk;

  logic [7:0] mem [16];
  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int newd_cnt = 0, newd_cyc = 0, rdy_cyc = 0, ack_cnt = 0, ack_cyc = 0;
  int bus_waits = 0;
  bit bus_stall = 0, bus_kill = 0;
  bit track = 0;
  int unstable = 0;
  logic [3:0] exp_addr;
  logic [7:0] exp_wd;
  logic       exp_wr;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(negedge pclk);
    #1;
  endtask

  task automatic set_req(input int idx, input logic wr, input logic [3:0] addr,
                         input logic [7:0] wd);
    bus.req_wr[idx]             = wr;
    bus.req_addr[idx*AW +: AW]  = addr;
    bus.req_wdata[idx*DW +: DW] = wd;
    bus.req[idx]                = 1'b1;
  endtask

  task automatic wait_ack(output logic [3:0] a);
    int n;
    n = 0;
    a = '0;
    while (a == 4'b0 && n < 200) begin
      step();
      if (bus.ack != 4'b0) a = bus.ack;
      n++;
    end
    chk("ack_wait", (n < 200), 1);
  endtask

  task automatic do_reset();
    preset   = 1'b1;
    bus_kill = 1'b1;
    step();
    step();
    preset = 1'b0;
    step();
    bus_kill = 1'b0;
  endtask

  // Sampling monitor on the falling edge.
  always @(negedge pclk) begin
    cyc++;
    if (bus.m_newd) begin
      newd_cnt++;
      newd_cyc = cyc;
    end
    if (bus.psel && bus.penable && bus.pready) rdy_cyc = cyc;
    if (bus.ack != 4'b0) begin
      ack_cnt++;
      ack_cyc = cyc;
    end
    if (track && bus.busy &&
        (bus.m_addr !== exp_addr || bus.m_wdata !== exp_wd || bus.m_wr !== exp_wr))
      unstable++;
  end

  // APB master + zero/N-wait slave model driven by m_newd.
  initial begin
    int w;
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    bus.pready  = 1'b0;
    bus.prdata  = '0;
    forever begin
      @(posedge pclk);
      #1;
      if (bus.m_newd && !preset) begin
        @(posedge pclk); #1;
        if (!bus_kill) begin
          bus.psel    = 1'b1;
          bus.penable = 1'b0;
        end
        @(posedge pclk); #1;
        if (!bus_kill) bus.penable = 1'b1;
        w = 0;
        while (!bus_kill && (bus_stall || w < bus_waits)) begin
          w++;
          @(posedge pclk); #1;
        end
        if (!bus_kill) begin
          bus.pready = 1'b1;
          if (bus.m_wr) mem[bus.m_addr] = bus.m_wdata;
          else bus.prdata = mem[bus.m_addr];
          @(posedge pclk); #1;
        end
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        bus.pready  = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d expected=%0d", cyc, 0);
    $fatal(1, "bench time limit");
  end

  initial begin
    logic [3:0] a;
    int req_cyc, n0, n;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    bus.req       = '0;
    bus.req_wr    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    preset = 1'b1;
    step(); step(); step();
    preset = 1'b0;
    step();

    // Reset state
    chk("rst_ack",     bus.ack,     0);
    chk("rst_rdata",   bus.rdata,   0);
    chk("rst_newd",    bus.m_newd,  0);
    chk("rst_m_wr",    bus.m_wr,    0);
    chk("rst_m_addr",  bus.m_addr,  0);
    chk("rst_m_wdata", bus.m_wdata, 0);
    chk("rst_busy",    bus.busy,    0);
    chk("rst_timeout", bus.timeout, 0);

    // Single write from requester 0, no wait states
    n0 = newd_cnt;
    set_req(0, 1'b1, 4'h3, 8'hA5);
    req_cyc = cyc;
    wait_ack(a);
    bus.req[0] = 1'b0;
    chk("wr_ack",      a, 4'b0001);
    chk("wr_newd_lat", newd_cyc - req_cyc, 1);
    chk("wr_ack_lat",  ack_cyc - newd_cyc, 3);
    chk("wr_mem3",     mem[3], 8'hA5);
    step();
    chk("wr_newd_cnt", newd_cnt - n0, 1);
    chk("wr_busy_off", bus.busy, 0);
    chk("wr_ack_off",  bus.ack, 0);

    // Read back through requester 2
    set_req(2, 1'b0, 4'h3, 8'h00);
    wait_ack(a);
    bus.req[2] = 1'b0;
    chk("rd_ack",   a, 4'b0100);
    chk("rd_rdata", bus.rdata, 8'hA5);

    // Wait states, command stability, inputs ignored after latch
    step();
    step();
    bus_waits = 5;
    exp_addr = 4'h7; exp_wd = 8'h3C; exp_wr = 1'b1;
    unstable = 0;
    track = 1'b1;
    set_req(1, 1'b1, 4'h7, 8'h3C);
    step(); step(); step(); step();
    bus.req_addr[1*AW +: AW]  = 4'hE;
    bus.req_wdata[1*DW +: DW] = 8'h11;
    bus.req_wr[1]             = 1'b0;
    wait_ack(a);
    bus.req[1] = 1'b0;
    chk("ws_ack",      a, 4'b0010);
    chk("ws_rdy2ack",  ack_cyc - rdy_cyc, 1);
    chk("ws_newd2ack", ack_cyc - newd_cyc, 8);
    chk("ws_mem7",     mem[7], 8'h3C);
    chk("ws_mem14",    mem[14], 8'h00);
    step();
    track = 1'b0;
    chk("ws_stable",   unstable, 0);
    bus_waits = 0;

    // Fairness from reset with all four requesting continuously
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 4'(i), 8'h00);
    for (int k = 0; k < 8; k++) begin
      wait_ack(a);
      chk($sformatf("fair_%0d", k), a, 32'(1) << (k % 4));
    end
    bus.req = '0;
    step();
    step();

    // Watchdog with a stalled slave
    do_reset();
    bus_stall = 1'b1;
    n0 = newd_cnt;
    n0 = ack_cnt;
    set_req(3, 1'b1, 4'h5, 8'h5A);
    n = 0;
    while (bus.m_newd !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    chk("to_newd_seen", (n < 50), 1);
    for (int i = 0; i < TO - 1; i++) step();
    chk("to_before", bus.timeout, 0);
    step();
    chk("to_rise", bus.timeout, 1);
    step(); step(); step();
    chk("to_sticky", bus.timeout, 1);
    chk("to_busy",   bus.busy, 1);
    chk("to_no_ack", ack_cnt - n0, 0);
    preset   = 1'b1;
    bus_kill = 1'b1;
    bus.req  = '0;
    step();
    chk("to_rst_timeout", bus.timeout, 0);
    chk("to_rst_busy",    bus.busy, 0);
    preset = 1'b0;
    step(); step();
    bus_kill  = 1'b0;
    bus_stall = 1'b0;

    // Reset in the middle of a transfer
    bus_waits = 20;
    set_req(1, 1'b1, 4'h9, 8'h77);
    n = 0;
    while (!(bus.psel && bus.penable) && n < 50) begin
      step();
      n++;
    end
    chk("mr_access_seen", (n < 50), 1);
    step(); step();
    n0 = ack_cnt;
    preset   = 1'b1;
    bus_kill = 1'b1;
    bus.req  = '0;
    step();
    chk("mr_ack",     bus.ack, 0);
    chk("mr_busy",    bus.busy, 0);
    chk("mr_newd",    bus.m_newd, 0);
    chk("mr_m_wr",    bus.m_wr, 0);
    chk("mr_m_addr",  bus.m_addr, 0);
    chk("mr_m_wdata", bus.m_wdata, 0);
    chk("mr_rdata",   bus.rdata, 0);
    preset = 1'b0;
    step(); step();
    bus_kill  = 1'b0;
    bus_waits = 0;
    step(); step(); step();
    chk("mr_no_ack", ack_cnt - n0, 0);
    chk("mr_mem9",   mem[9], 8'h00);
    set_req(1, 1'b0, 4'h3, 8'h00);
    wait_ack(a);
    bus.req[1] = 1'b0;
    chk("mr_regrant_ack", a, 4'b0010);
    chk("mr_regrant_rd",  bus.rdata, 8'hA5);
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
